change_dispense_ctrl: RTL
=========================

// Module: change_dispense_ctrl
// PURPOSE
//   Sequences the coin-return mechanism after a purchase. It takes a change
//   amount in cents and ejects quarters, dimes and nickels one at a time over a
//   req/ack handshake to the hopper actuator. It tracks per-coin hopper
//   inventory, incremented by accepted coin deposits and decremented by ejects.
//   It sits between the credit/purchase datapath and the coin hopper driver.
// PARAMETERS
//   CENTS_W      16         width of amount/remaining fields (cents)
//   CNT_W        8          width of each hopper inventory counter
//   ACK_TIMEOUT  1000000    max cycles in EJECT waiting for ack before fault
//   INIT_Q       4          quarter inventory after reset
//   INIT_D       4          dime inventory after reset
//   INIT_N       4          nickel inventory after reset
// PORTS
//   clock        in   1        system clock, all logic on rising edge
//   reset_n      in   1        asynchronous, active-low reset
//   start        in   1        1-cycle pulse: begin dispensing change_amt
//   change_amt   in   CENTS_W  change to return, sampled only when start accepted
//   dep_nickel   in   1        1-cycle pulse: debounced nickel accepted into hopper
//   dep_dime     in   1        1-cycle pulse: debounced dime accepted into hopper
//   dep_quarter  in   1        1-cycle pulse: debounced quarter accepted into hopper
//   eject_ack    in   1        hopper driver ack (level), 4-phase handshake
//   eject_req    out  1        request one coin ejection of type eject_sel
//   eject_sel    out  2        00=none 01=nickel 10=dime 11=quarter
//   busy         out  1        high in every state except IDLE
//   done         out  1        1-cycle pulse: change fully returned
//   fault        out  1        1-cycle pulse: change could not be completed
//   remaining    out  CENTS_W  cents still owed; holds value after done/fault
//   cnt_q/cnt_d/cnt_n out CNT_W each  current hopper inventory
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE, eject_req=0, eject_sel=00, busy=0,
//     done=0, fault=0, remaining=0, cnt_q/d/n=INIT_Q/D/N, timeout ctr=0.
//     Reset mid-handshake drops eject_req immediately. Coin in flight is not counted.
//   States: IDLE, SELECT, EJECT, RELEASE, DONE, FAULT.
//   IDLE: start=1 -> remaining<=change_amt, go SELECT. start is ignored in all other states.
//   SELECT (1 cycle), greedy, evaluated in order:
//     remaining==0 -> DONE
//     remaining>=25 & cnt_q>0 -> sel=11, EJECT
//     remaining>=10 & cnt_d>0 -> sel=10, EJECT
//     remaining>=5  & cnt_n>0 -> sel=01, EJECT
//     otherwise -> FAULT
//     This covers a non-multiple-of-5 residue and an exhausted hopper.
//   Greedy is final. No backtracking: 30c with cnt_n=0, cnt_q>0 ejects Q then faults with 5 left.
//   EJECT: eject_req=1, eject_sel stable. The timeout counter increments each cycle.
//     ack=1 -> same edge: remaining -= coin value, selected count -= 1; go RELEASE.
//     Counter reaching ACK_TIMEOUT-1 without ack -> FAULT, no decrement.
//   RELEASE: eject_req=0, sel held. Wait for ack=0, then clear timeout ctr and go SELECT.
//     Minimum per-coin latency is SELECT+EJECT+RELEASE = 3 cycles.
//   DONE: done=1 for one cycle, then IDLE. FAULT: fault=1 for one cycle, then IDLE.
//     eject_sel=00 in IDLE/DONE/FAULT.
//   Deposits are accepted in any state. Each dep_* pulse increments its counter,
//     which saturates at 2^CNT_W-1.
//   Deposit and eject-decrement of the same coin type on one edge -> net no change.
//   Simultaneous deposits of different types all apply on the same edge.
//   A deposit arriving during SELECT is visible at the next SELECT, not the current one.
//   Arithmetic is unsigned. remaining never underflows because the selection guards it.
// TESTING
//   1. Inventory 4/4/4, start with amt=40 -> ejects Q,D,N. done after the 3rd RELEASE.
//      remaining=0, counts 3/3/3.
//   2. amt=0 -> SELECT->DONE. done pulses 2 cycles after start. No eject_req.
//   3. cnt_n=0, amt=30 -> Q ejected, then fault. remaining=5, cnt_q=3.
//   4. Hold ack low with ACK_TIMEOUT=16, amt=25 -> fault 16 cycles after EJECT entry.
//      remaining=25, cnt_q unchanged.
//   5. dep_quarter on the same edge as the Q ack -> cnt_q unchanged. Counter at 255 plus dep -> stays 255.
//   6. Drop reset_n during EJECT -> eject_req falls without a clock edge. All outputs at reset values.
//      start issued after release is accepted normally.

Source files
------------

// File: rtl/change_dispense_ctrl.sv
// Coin-return sequencer: greedily ejects quarters, dimes and nickels over a 4-phase
// req/ack handshake and keeps a saturating per-coin hopper inventory.

module coin_counter #(
    parameter int CNT_W = 8,
    parameter int INIT  = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Deposit and eject of the same coin on one edge cancel out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= CNT_W'(INIT);
        end else if (inc && !dec) begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end else if (dec && !inc) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

module change_dispense_ctrl #(
    parameter int CENTS_W     = 16,
    parameter int CNT_W       = 8,
    parameter int ACK_TIMEOUT = 1000000,
    parameter int INIT_Q      = 4,
    parameter int INIT_D      = 4,
    parameter int INIT_N      = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [CENTS_W-1:0] change_amt,
    input  logic               dep_nickel,
    input  logic               dep_dime,
    input  logic               dep_quarter,
    input  logic               eject_ack,
    output logic               eject_req,
    output logic [1:0]         eject_sel,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [CENTS_W-1:0] remaining,
    output logic [CNT_W-1:0]   cnt_q,
    output logic [CNT_W-1:0]   cnt_d,
    output logic [CNT_W-1:0]   cnt_n
);
    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_N    = 2'b01;
    localparam logic [1:0] SEL_D    = 2'b10;
    localparam logic [1:0] SEL_Q    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_RELEASE,
        S_DONE,
        S_FAULT
    } state_t;

    state_t             state, state_nx;
    logic [1:0]         sel_r, sel_nx;
    logic [TMO_W-1:0]   tmo_r, tmo_nx;
    logic [CENTS_W-1:0] rem_r, rem_nx;
    logic               dec_en;
    logic [CENTS_W-1:0] coin_val;

    // Inventory index: 0 = nickel, 1 = dime, 2 = quarter.
    wire  [2:0][CNT_W-1:0] cnt;
    logic [2:0]            dep;
    logic [2:0]            dec;

    assign dep = {dep_quarter, dep_dime, dep_nickel};
    assign dec = {dec_en && (sel_r == SEL_Q),
                  dec_en && (sel_r == SEL_D),
                  dec_en && (sel_r == SEL_N)};

    always_comb begin
        coin_val = '0;
        case (sel_r)
            SEL_Q:   coin_val = CENTS_W'(25);
            SEL_D:   coin_val = CENTS_W'(10);
            SEL_N:   coin_val = CENTS_W'(5);
            default: coin_val = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            sel_r <= SEL_NONE;
            tmo_r <= '0;
            rem_r <= '0;
        end else begin
            state <= state_nx;
            sel_r <= sel_nx;
            tmo_r <= tmo_nx;
            rem_r <= rem_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel_r;
        tmo_nx   = tmo_r;
        rem_nx   = rem_r;
        dec_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    rem_nx   = change_amt;
                    state_nx = S_SELECT;
                end
            end
            // Greedy pick against the inventory as registered; no backtracking later.
            S_SELECT: begin
                tmo_nx = '0;
                if (rem_r == '0) begin
                    state_nx = S_DONE;
                end else if (rem_r >= CENTS_W'(25) && cnt[2] != '0) begin
                    sel_nx   = SEL_Q;
                    state_nx = S_EJECT;
                end else if (rem_r >= CENTS_W'(10) && cnt[1] != '0) begin
                    sel_nx   = SEL_D;
                    state_nx = S_EJECT;
                end else if (rem_r >= CENTS_W'(5) && cnt[0] != '0) begin
                    sel_nx   = SEL_N;
                    state_nx = S_EJECT;
                end else begin
                    state_nx = S_FAULT;
                end
            end
            S_EJECT: begin
                if (eject_ack) begin
                    rem_nx   = rem_r - coin_val;
                    dec_en   = 1'b1;
                    state_nx = S_RELEASE;
                end else if (tmo_r == TMO_LAST) begin
                    state_nx = S_FAULT;
                end else begin
                    tmo_nx = tmo_r + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!eject_ack) begin
                    tmo_nx   = '0;
                    state_nx = S_SELECT;
                end
            end
            S_DONE: begin
                tmo_nx   = '0;
                state_nx = S_IDLE;
            end
            S_FAULT: begin
                tmo_nx   = '0;
                state_nx = S_IDLE;
            end
            default: begin
                tmo_nx   = '0;
                state_nx = S_IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < 3; i++) begin : g_cnt
        coin_counter #(
            .CNT_W (CNT_W),
            .INIT  ((i == 2) ? INIT_Q : (i == 1) ? INIT_D : INIT_N)
        ) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .inc     (dep[i]),
            .dec     (dec[i]),
            .cnt     (cnt[i])
        );
    end

    // Outputs decode straight from state so an async reset drops eject_req at once.
    assign eject_req = (state == S_EJECT);
    assign eject_sel = (state == S_EJECT || state == S_RELEASE) ? sel_r : SEL_NONE;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign fault     = (state == S_FAULT);
    assign remaining = rem_r;
    assign cnt_q     = cnt[2];
    assign cnt_d     = cnt[1];
    assign cnt_n     = cnt[0];
endmodule
